rz_decode: RTL and testbench

Receive-side decoder for the WS2812 return-to-zero one-wire line. It samples a serial RZ input, classifies each high pulse as a 0 or 1 bit, and assembles 24-bit words MSB-first. It detects the low-time latch (reset) code that ends a frame. It sits opposite the RZ transmitter as a loopback checker or pixel-chain sniffer, and reports each decoded word, its pixel index, frame completion and protocol errors.

---
 rtl/rz_decode.sv | 177 +++++++++++++++++
 tb/tb_rz_decode.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rz_decode.sv
// WS2812 return-to-zero line decoder: measures high pulses, assembles 24-bit
// MSB-first words, and reports words, pixel index, frame latch and errors.
module rz_decode #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BIT_THRESH = 30,
  parameter int HIGH_MIN   = 5,
  parameter int HIGH_MAX   = 100,
  parameter int RST_CYCLES = 2500,
  parameter int PIX_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RZ_data,
  output logic [23:0]      rx_data,
  output logic             rx_valid,
  output logic [PIX_W-1:0] pixel_cnt,
  output logic             frame_done,
  output logic             rx_err,
  output logic [1:0]       dbg_state
);

  // Output pulses (rx_valid, frame_done, rx_err) are single-cycle strobes with
  // no ready/back-pressure: a consumer must capture rx_data/pixel_cnt on the
  // cycle rx_valid is high, and rx_data then holds until the next rx_valid.

  if (CLK_FREQ <= 0 || HIGH_MIN < 1 || BIT_THRESH >= HIGH_MAX) begin : g_bad_params
    $error("rz_decode: inconsistent timing parameters");
  end

  localparam int HW = $clog2(HIGH_MAX + 1);
  localparam int LW = $clog2(RST_CYCLES + 1);

  localparam logic [HW-1:0] HI_MIN  = HW'(HIGH_MIN);
  localparam logic [HW-1:0] HI_THR  = HW'(BIT_THRESH);
  localparam logic [HW-1:0] HI_LAST = HW'(HIGH_MAX - 1);
  localparam logic [HW-1:0] HI_MAX  = HW'(HIGH_MAX);
  localparam logic [LW-1:0] LO_MAX  = LW'(RST_CYCLES);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic [HW-1:0]    hi_cnt_q, hi_cnt_d;
  logic [LW-1:0]    lo_cnt_q, lo_cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [22:0]      shift_q, shift_d;
  logic             latched_q, latched_d;
  logic             have_word_q, have_word_d;
  logic [PIX_W-1:0] next_pix_q, next_pix_d;
  logic [23:0]      rx_data_d;
  logic [PIX_W-1:0] pixel_cnt_d;
  logic             rx_valid_d, frame_done_d, rx_err_d;
  logic             s;
  logic [23:0]      word_next;

  assign s         = sync_q[1];
  assign word_next = {shift_q, (hi_cnt_q >= HI_THR)};
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SYNC;
      sync_q      <= '0;
      hi_cnt_q    <= '0;
      lo_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      latched_q   <= 1'b0;
      have_word_q <= 1'b0;
      next_pix_q  <= '0;
      rx_data     <= '0;
      pixel_cnt   <= '0;
      rx_valid    <= 1'b0;
      frame_done  <= 1'b0;
      rx_err      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], RZ_data};
      hi_cnt_q    <= hi_cnt_d;
      lo_cnt_q    <= lo_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      latched_q   <= latched_d;
      have_word_q <= have_word_d;
      next_pix_q  <= next_pix_d;
      rx_data     <= rx_data_d;
      pixel_cnt   <= pixel_cnt_d;
      rx_valid    <= rx_valid_d;
      frame_done  <= frame_done_d;
      rx_err      <= rx_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hi_cnt_d     = hi_cnt_q;
    lo_cnt_d     = lo_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    latched_d    = latched_q;
    have_word_d  = have_word_q;
    next_pix_d   = next_pix_q;
    rx_data_d    = rx_data;
    pixel_cnt_d  = pixel_cnt;
    rx_valid_d   = 1'b0;
    frame_done_d = 1'b0;
    rx_err_d     = 1'b0;
    case (state_q)
      SYNC, ERR: begin
        // Entering LOW already marked as latched so no frame/err pulse follows.
        if (s) lo_cnt_d = '0;
        else if (lo_cnt_q != LO_MAX) lo_cnt_d = lo_cnt_q + 1'b1;
        else begin
          state_d   = LOW;
          latched_d = 1'b1;
        end
      end
      LOW: begin
        if (s) begin
          // The rising-edge sample is the first high cycle of the pulse.
          state_d  = HIGH;
          hi_cnt_d = HW'(1);
        end else if (lo_cnt_q != LO_MAX) begin
          lo_cnt_d = lo_cnt_q + 1'b1;
        end else if (!latched_q) begin
          latched_d    = 1'b1;
          rx_err_d     = (bit_cnt_q != 5'd0);
          frame_done_d = have_word_q;
          have_word_d  = 1'b0;
          bit_cnt_d    = '0;
          next_pix_d   = '0;
        end
      end
      HIGH: begin
        if (s) begin
          if (hi_cnt_q >= HI_LAST) begin
            rx_err_d    = 1'b1;
            state_d     = ERR;
            hi_cnt_d    = HI_MAX;
            lo_cnt_d    = '0;
            bit_cnt_d   = '0;
            have_word_d = 1'b0;
            next_pix_d  = '0;
            pixel_cnt_d = '0;
          end else begin
            hi_cnt_d = hi_cnt_q + 1'b1;
          end
        end else begin
          // Glitches return to LOW leaving lo_cnt and bit_cnt untouched.
          state_d = LOW;
          if (hi_cnt_q >= HI_MIN) begin
            shift_d   = word_next[22:0];
            lo_cnt_d  = '0;
            latched_d = 1'b0;
            if (bit_cnt_q == 5'd23) begin
              rx_data_d   = word_next;
              rx_valid_d  = 1'b1;
              pixel_cnt_d = next_pix_q;
              next_pix_d  = next_pix_q + 1'b1;
              have_word_d = 1'b1;
              bit_cnt_d   = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

endmodule

// File: tb/tb_rz_decode.sv
// Bench for rz_decode: drives RZ pulses and compares against a pulse-level
// model of the line protocol (bit classification, word/frame bookkeeping).
module tb_rz_decode;
  localparam int RST  = 2500;
  localparam int HMIN = 5;
  localparam int HMAX = 100;
  localparam int THR  = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RZ_data = 1'b0;
  logic [23:0] rx_data;
  logic        rx_valid;
  logic [9:0]  pixel_cnt;
  logic        frame_done;
  logic        rx_err;
  logic [1:0]  dbg_state;

  rz_decode dut (
    .clk(clk), .rst_n(rst_n), .RZ_data(RZ_data), .rx_data(rx_data),
    .rx_valid(rx_valid), .pixel_cnt(pixel_cnt), .frame_done(frame_done),
    .rx_err(rx_err), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];
  int frames_seen, errs_seen, exp_frames, exp_errs;
  int fd_cyc, valid_cyc, fall_cyc;
  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  bit          m_sync;
  int          m_bits;
  logic [23:0] m_word;
  int          m_pix;
  bit          m_have;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        obs_q.push_back({pixel_cnt, rx_data});
        valid_cyc = cyc;
      end
      if (frame_done) begin
        frames_seen++;
        fd_cyc = cyc;
      end
      if (rx_err) errs_seen++;
    end
  end

  task automatic model_low(input int lo);
    if (lo >= RST + 2) begin
      if (m_sync) begin
        if (m_bits != 0) exp_errs++;
        if (m_have) exp_frames++;
        m_bits = 0;
        m_have = 0;
        m_pix  = 0;
      end
      m_sync = 1;
    end
  endtask

  task automatic model_reset();
    m_sync = 0; m_bits = 0; m_have = 0; m_pix = 0; m_word = '0;
  endtask

  // driver: one high pulse of hi cycles followed by lo cycles of low line
  task automatic drive_pulse(input int hi, input int lo);
    if (m_sync) begin
      if (hi >= HMAX) begin
        exp_errs++;
        m_sync = 0; m_bits = 0; m_have = 0; m_pix = 0;
      end else if (hi >= HMIN) begin
        m_word = {m_word[22:0], (hi >= THR)};
        m_bits++;
        if (m_bits == 24) begin
          exp_q.push_back({10'(m_pix), m_word});
          m_pix  = (m_pix + 1) % 1024;
          m_have = 1;
          m_bits = 0;
        end
      end
    end
    model_low(lo);
    RZ_data = 1'b1;
    repeat (hi) begin @(posedge clk); #1; end
    RZ_data = 1'b0;
    fall_cyc = cyc;
    repeat (lo) begin @(posedge clk); #1; end
  endtask

  // sends w[n-1:0] MSB first; last_lo < 0 keeps the regular bit period
  task automatic send_bits(input logic [23:0] w, input int n, input int t0h,
                           input int t1h, input int period, input int last_lo);
    for (int i = n - 1; i >= 0; i--) begin
      int hi;
      hi = w[i] ? t1h : t0h;
      drive_pulse(hi, (i == 0 && last_lo >= 0) ? last_lo : period - hi);
    end
  endtask

  task automatic idle(input int n);
    model_low(n);
    RZ_data = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_test();
    obs_q.delete(); exp_q.delete();
    frames_seen = 0; errs_seen = 0; exp_frames = 0; exp_errs = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    RZ_data = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    n_checks++; if (rx_data !== 24'h0) begin n_fail++; $display("FAIL reset_rx_data got %h want 000000", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    n_checks++; if (pixel_cnt !== 10'd0) begin n_fail++; $display("FAIL reset_pixel_cnt got %0d want 0", pixel_cnt); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    n_checks++; if (rx_err !== 1'b0) begin n_fail++; $display("FAIL reset_rx_err got %b want 0", rx_err); end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    start_test();
    idle(RST + 10);
    send_bits(24'hA5C30F, 24, 20, 40, 62, RST + 10);
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL single_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      n_checks++; if (obs_q[0] !== {10'd0, 24'hA5C30F}) begin n_fail++; $display("FAIL single_word got %h want %h", obs_q[0], {10'd0, 24'hA5C30F}); end
      n_checks++; if (obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL single_model got %h want %h", obs_q[0], exp_q[0]); end
    end
    n_checks++; if (valid_cyc - fall_cyc != 3) begin n_fail++; $display("FAIL single_valid_latency got %0d want 3", valid_cyc - fall_cyc); end
    n_checks++; if (frames_seen != 1) begin n_fail++; $display("FAIL single_frames got %0d want 1", frames_seen); end
    n_checks++; if (fd_cyc - fall_cyc != 2504) begin n_fail++; $display("FAIL single_frame_latency got %0d want 2504", fd_cyc - fall_cyc); end
    n_checks++; if (errs_seen != 0) begin n_fail++; $display("FAIL single_errs got %0d want 0", errs_seen); end
  endtask

  task automatic test_back_to_back();
    int pix_want[4] = '{0, 1, 2, 0};
    start_test();
    send_bits(24'hFF0000, 24, 10, 40, 46, -1);
    send_bits(24'h00FF00, 24, 10, 40, 46, -1);
    send_bits(24'h0000FF, 24, 10, 40, 46, RST + 10);
    n_checks++; if (frames_seen != 1) begin n_fail++; $display("FAIL b2b_first_frame got %0d want 1", frames_seen); end
    send_bits(24'h123456, 24, 10, 40, 46, RST + 10);
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i][33:24] !== 10'(pix_want[i])) begin n_fail++; $display("FAIL b2b_pix[%0d] got %0d want %0d", i, obs_q[i][33:24], pix_want[i]); end
    end
    n_checks++; if (frames_seen != 2) begin n_fail++; $display("FAIL b2b_frames got %0d want 2", frames_seen); end
    n_checks++; if (errs_seen != 0) begin n_fail++; $display("FAIL b2b_errs got %0d want 0", errs_seen); end
  endtask

  task automatic test_partial_latch();
    start_test();
    send_bits(24'h000ABC, 12, 10, 40, 46, RST + 10);
    n_checks++; if (errs_seen != 1) begin n_fail++; $display("FAIL partial_err got %0d want 1", errs_seen); end
    n_checks++; if (frames_seen != 0) begin n_fail++; $display("FAIL partial_frame got %0d want 0", frames_seen); end
    send_bits(24'h5A5A5A, 24, 10, 40, 46, RST + 10);
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL partial_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      n_checks++; if (obs_q[0] !== {10'd0, 24'h5A5A5A}) begin n_fail++; $display("FAIL partial_word got %h want %h", obs_q[0], {10'd0, 24'h5A5A5A}); end
    end
    n_checks++; if (errs_seen != exp_errs) begin n_fail++; $display("FAIL partial_errs got %0d want %0d", errs_seen, exp_errs); end
  endtask

  task automatic test_glitch_overlong();
    start_test();
    send_bits(24'h00003C, 12, 10, 40, 46, 10);
    drive_pulse(2, 10);
    send_bits(24'h0003C3, 12, 10, 40, 46, RST + 10);
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL glitch_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      n_checks++; if (obs_q[0] !== {10'd0, 24'h03C3C3}) begin n_fail++; $display("FAIL glitch_word got %h want %h", obs_q[0], {10'd0, 24'h03C3C3}); end
    end
    send_bits(24'h000111, 12, 10, 40, 46, 10);
    drive_pulse(HMAX, 100);
    n_checks++; if (errs_seen != 1) begin n_fail++; $display("FAIL overlong_err got %0d want 1", errs_seen); end
    send_bits(24'h777777, 24, 10, 40, 46, RST + 10);
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL overlong_nodecode got %0d want 1", obs_q.size()); end
    // boundary pulse lengths: HIGH_MIN, BIT_THRESH-1 as 0; BIT_THRESH, HIGH_MAX-1 as 1
    send_bits(24'h81C3E7, 12, HMIN, HMAX - 1, 110, -1);
    send_bits(24'h81C3E7, 12, THR - 1, THR, 40, RST + 10);
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL glitch_total got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL glitch_seq[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (frames_seen != exp_frames) begin n_fail++; $display("FAIL glitch_frames got %0d want %0d", frames_seen, exp_frames); end
    n_checks++; if (errs_seen != exp_errs) begin n_fail++; $display("FAIL glitch_errs got %0d want %0d", errs_seen, exp_errs); end
  endtask

  task automatic test_no_sync();
    start_test();
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    model_reset();
    rst_n = 1'b1;
    send_bits(24'hDEADBE, 24, 10, 40, 46, RST + 10);
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL nosync_valid got %0d want 0", obs_q.size()); end
    send_bits(24'h13579B, 24, 10, 40, 46, RST + 10);
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL nosync_after got %0d want 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      n_checks++; if (obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL nosync_word got %h want %h", obs_q[0], exp_q[0]); end
    end
    n_checks++; if (frames_seen != 1) begin n_fail++; $display("FAIL nosync_frames got %0d want 1", frames_seen); end
  endtask

  task automatic test_reset_mid_word();
    start_test();
    send_bits(24'h0A0B0C, 24, 10, 40, 46, -1);
    send_bits(24'hC0FFEE, 24, 10, 40, 46, -1);
    send_bits(24'h0002AA, 10, 10, 40, 46, -1);
    n_checks++; if (pixel_cnt !== 10'd1) begin n_fail++; $display("FAIL midrst_pre_pix got %0d want 1", pixel_cnt); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({rx_data, pixel_cnt, rx_valid, frame_done, rx_err} !== 37'd0) begin
      n_fail++; $display("FAIL midrst_outputs got data=%h pix=%0d v=%b fd=%b err=%b want all 0", rx_data, pixel_cnt, rx_valid, frame_done, rx_err);
    end
    repeat (2) begin @(posedge clk); #1; end
    model_reset();
    rst_n = 1'b1;
    idle(RST + 10);
    send_bits(24'h2468AC, 24, 10, 40, 46, RST + 10);
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (frames_seen != 1 || errs_seen != 0) begin n_fail++; $display("FAIL midrst_pulses got fd=%0d err=%0d want fd=1 err=0", frames_seen, errs_seen); end
  endtask

  task automatic test_random();
    start_test();
    for (int f = 0; f < 3; f++) begin
      int nw, t0h, t1h, period;
      nw     = $urandom_range(1, 2);
      t0h    = $urandom_range(HMIN + 3, THR - 3);
      t1h    = $urandom_range(THR + 3, 60);
      period = t1h + $urandom_range(6, 20);
      for (int w = 0; w < nw; w++) begin
        logic [23:0] word;
        word = 24'($urandom);
        if (w == nw - 1) send_bits(word, 24, t0h, t1h, period, RST + $urandom_range(10, 100));
        else begin
          send_bits(word, 24, t0h, t1h, period, -1);
          if ($urandom_range(0, 1) == 1) drive_pulse($urandom_range(1, HMIN - 1), $urandom_range(3, 20));
        end
      end
    end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (frames_seen != exp_frames) begin n_fail++; $display("FAIL rand_frames got %0d want %0d", frames_seen, exp_frames); end
    n_checks++; if (errs_seen != exp_errs) begin n_fail++; $display("FAIL rand_errs got %0d want %0d", errs_seen, exp_errs); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_word();
    test_back_to_back();
    test_partial_latch();
    test_glitch_overlong();
    test_no_sync();
    test_reset_mid_word();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
